// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with runtime parity selection.
// Deserialises an LSB-first serial line into NB_DATA-bit words. Every received
// word comes with parity-error, framing-error and break flags.
module uart_rx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int NB_STOP    = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_data,
  input  logic               i_parity_en,
  input  logic               i_parity_odd,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rxdone,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(NB_DATA - 1);
  localparam logic [3:0]    LAST_STOP = 4'(NB_STOP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic               r_sync1, r_sync2;
  logic               w_rxS;

  state_t             r_state, w_state;
  logic [CW-1:0]      r_tickCnt, w_tickCnt;
  logic [3:0]         r_bitCnt, w_bitCnt;
  logic [NB_DATA-1:0] r_shift, w_shift;
  logic               r_xor, w_xor;
  logic               r_parEn, w_parEn;
  logic               r_parOdd, w_parOdd;
  logic               r_parErrAcc, w_parErrAcc;
  logic               r_frameAcc, w_frameAcc;
  logic               r_breakAcc, w_breakAcc;
  logic               w_frameNow, w_breakNow;

  logic [NB_DATA-1:0] r_data, w_data;
  logic               r_rxDone, w_rxDone;
  logic               r_parErr, w_parErr;
  logic               r_frameErr, w_frameErr;
  logic               r_break, w_break;

  assign w_rxS = r_sync2;

  // Two-flop synchroniser for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_data;
      r_sync2 <= r_sync1;
    end
  end

  // State register plus all frame datapath and output registers.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_tickCnt   <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_xor       <= 1'b0;
      r_parEn     <= 1'b0;
      r_parOdd    <= 1'b0;
      r_parErrAcc <= 1'b0;
      r_frameAcc  <= 1'b0;
      r_breakAcc  <= 1'b0;
      r_data      <= '0;
      r_rxDone    <= 1'b0;
      r_parErr    <= 1'b0;
      r_frameErr  <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_tickCnt   <= w_tickCnt;
      r_bitCnt    <= w_bitCnt;
      r_shift     <= w_shift;
      r_xor       <= w_xor;
      r_parEn     <= w_parEn;
      r_parOdd    <= w_parOdd;
      r_parErrAcc <= w_parErrAcc;
      r_frameAcc  <= w_frameAcc;
      r_breakAcc  <= w_breakAcc;
      r_data      <= w_data;
      r_rxDone    <= w_rxDone;
      r_parErr    <= w_parErr;
      r_frameErr  <= w_frameErr;
      r_break     <= w_break;
    end
  end

  // Next-state and datapath logic; everything advances only on a baud tick.
  always_comb begin
    w_state     = r_state;
    w_tickCnt   = r_tickCnt;
    w_bitCnt    = r_bitCnt;
    w_shift     = r_shift;
    w_xor       = r_xor;
    w_parEn     = r_parEn;
    w_parOdd    = r_parOdd;
    w_parErrAcc = r_parErrAcc;
    w_frameAcc  = r_frameAcc;
    w_breakAcc  = r_breakAcc;
    w_data      = r_data;
    w_rxDone    = 1'b0;
    w_parErr    = r_parErr;
    w_frameErr  = r_frameErr;
    w_break     = r_break;
    w_frameNow  = r_frameAcc | ~w_rxS;
    w_breakNow  = r_breakAcc & ~w_rxS;

    if (i_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxS) begin
            w_tickCnt   = '0;
            w_bitCnt    = '0;
            w_parEn     = i_parity_en;
            w_parOdd    = i_parity_odd;
            w_xor       = 1'b0;
            w_parErrAcc = 1'b0;
            w_frameAcc  = 1'b0;
            w_breakAcc  = 1'b1;
            w_state     = S_START;
          end
        end
        S_START: begin
          if (r_tickCnt == HALF_TICK) begin
            if (!w_rxS) begin
              w_tickCnt = '0;
              w_state   = S_DATA;
            end else begin
              w_state = S_IDLE;
            end
          end else begin
            w_tickCnt = r_tickCnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tickCnt == LAST_TICK) begin
            w_tickCnt  = '0;
            w_shift    = {w_rxS, r_shift[NB_DATA-1:1]};
            w_xor      = r_xor ^ w_rxS;
            w_breakAcc = w_breakNow;
            if (r_bitCnt == LAST_DATA) begin
              w_bitCnt = '0;
              w_state  = r_parEn ? S_PARITY : S_STOP;
            end else begin
              w_bitCnt = r_bitCnt + 1'b1;
            end
          end else begin
            w_tickCnt = r_tickCnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_tickCnt == LAST_TICK) begin
            w_tickCnt   = '0;
            w_parErrAcc = ((r_xor ^ w_rxS) != r_parOdd);
            w_breakAcc  = w_breakNow;
            w_state     = S_STOP;
          end else begin
            w_tickCnt = r_tickCnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_tickCnt == LAST_TICK) begin
            w_tickCnt  = '0;
            w_frameAcc = w_frameNow;
            w_breakAcc = w_breakNow;
            if (r_bitCnt == LAST_STOP) begin
              w_bitCnt   = '0;
              w_rxDone   = 1'b1;
              w_data     = r_shift;
              w_parErr   = r_parErrAcc;
              w_frameErr = w_frameNow;
              w_break    = w_breakNow;
              w_state    = S_IDLE;
            end else begin
              w_bitCnt = r_bitCnt + 1'b1;
            end
          end else begin
            w_tickCnt = r_tickCnt + 1'b1;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_rxdone     = r_rxDone;
  assign o_parity_err = r_parErr;
  assign o_frame_err  = r_frameErr;
  assign o_break      = r_break;

endmodule
